// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared writeback state encoding and default sizing
package writeback_unit_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_TIMEOUT    = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - instruction, memory-return and register-file write signals
interface writeback_unit_if
  import writeback_unit_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic                      reg_write;
  logic                      mem_to_reg;
  logic                      load_byte;
  logic                      byte_sel;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [REG_DATA_WIDTH-1:0] alu_result;
  logic [REG_DATA_WIDTH-1:0] mem_rdata;
  logic                      mem_rvalid;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [REG_DATA_WIDTH-1:0] rf_wdata;
  logic                      err;

  modport slave (
    input  in_valid, reg_write, mem_to_reg, load_byte, byte_sel, rd_addr,
           alu_result, mem_rdata, mem_rvalid,
    output in_ready, rf_we, rf_waddr, rf_wdata, err
  );

  modport master (
    output in_valid, reg_write, mem_to_reg, load_byte, byte_sel, rd_addr,
           alu_result, mem_rdata, mem_rvalid,
    input  in_ready, rf_we, rf_waddr, rf_wdata, err
  );

endinterface

// File: rtl/writeback_unit_load_formatter.sv
// rtl/writeback_unit_load_formatter.sv - narrows byte loads to one lane and sign-extends
module load_formatter
  import writeback_unit_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      load_byte,
  input  logic                      byte_sel,
  input  logic [REG_DATA_WIDTH-1:0] mem_rdata,
  output logic [REG_DATA_WIDTH-1:0] data
);

  logic [7:0] lane;

  always_comb begin
    lane = byte_sel ? mem_rdata[15:8] : mem_rdata[7:0];
    if (load_byte) begin
      data = {{(REG_DATA_WIDTH-8){lane[7]}}, lane};
    end else begin
      data = mem_rdata;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage: one register-file write per instruction,
// waiting on load data with a bounded timeout
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  writeback_unit_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e                 state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [REG_ADDR_WIDTH-1:0] ld_addr, ld_addr_next;
  logic                      ld_byte, ld_byte_next;
  logic                      ld_sel, ld_sel_next;
  logic                      we_q, we_next;
  logic                      err_q, err_next;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_next;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_next;
  logic [REG_DATA_WIDTH-1:0] fmt_data;
  logic                      ready;

  load_formatter #(.REG_DATA_WIDTH(REG_DATA_WIDTH)) u_fmt (
    .load_byte (ld_byte),
    .byte_sel  (ld_sel),
    .mem_rdata (bus.mem_rdata),
    .data      (fmt_data)
  );

  assign ready        = (state == ST_IDLE) || (state == ST_WRITE);
  assign bus.in_ready = ready;
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.err      = err_q;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ld_addr_next = ld_addr;
    ld_byte_next = ld_byte;
    ld_sel_next  = ld_sel;
    we_next      = 1'b0;
    err_next     = 1'b0;
    waddr_next   = waddr_q;
    wdata_next   = wdata_q;

    case (state)
      ST_WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_next = ST_WRITE;
          if (ld_addr != '0) begin
            we_next    = 1'b1;
            waddr_next = ld_addr;
            wdata_next = fmt_data;
          end
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and WRITE accept identically, so back-to-back ALU writes stream
        state_next = ST_IDLE;
        if (bus.in_valid && ready && bus.reg_write) begin
          if (bus.mem_to_reg) begin
            state_next   = ST_WAIT_MEM;
            cnt_next     = '0;
            ld_addr_next = bus.rd_addr;
            ld_byte_next = bus.load_byte;
            ld_sel_next  = bus.byte_sel;
          end else begin
            state_next = ST_WRITE;
            if (bus.rd_addr != '0) begin
              we_next    = 1'b1;
              waddr_next = bus.rd_addr;
              wdata_next = bus.alu_result;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ld_addr <= '0;
      ld_byte <= 1'b0;
      ld_sel  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ld_addr <= ld_addr_next;
      ld_byte <= ld_byte_next;
      ld_sel  <= ld_sel_next;
      we_q    <= we_next;
      err_q   <= err_next;
      waddr_q <= waddr_next;
      wdata_q <= wdata_next;
    end
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage for the 16-bit datapath: accepts a completed instruction's ALU result or load request, waits for data memory read data when required, and issues one register-file write per instruction. It is the return end of the operand path: operands leave the register file through the operand mux, and results re-enter it here. Byte loads are narrowed and sign-extended before the write. Loads that never return data raise an error instead of hanging the pipeline.

## Interface
- REG_DATA_WIDTH, 16, register and data width
- REG_ADDR_WIDTH, 4, register-file address width
- TIMEOUT, 8, maximum WAIT_MEM cycles before a load is abandoned (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction presented this cycle
- in_ready  out  1  block can accept; combinational from state
- reg_write  in  1  instruction writes a register
- mem_to_reg  in  1  result comes from memory (load), not ALU
- load_byte  in  1  byte load (else full word)
- byte_sel  in  1  byte load lane: 0=[7:0], 1=[15:8]
- rd_addr  in  REG_ADDR_WIDTH  destination register
- alu_result  in  REG_DATA_WIDTH  ALU result
- mem_rdata  in  REG_DATA_WIDTH  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  REG_ADDR_WIDTH  write address, registered
- rf_wdata  out  REG_DATA_WIDTH  write data, registered
- err  out  1  one-cycle load-timeout pulse, registered

## Operation
- States: IDLE, WAIT_MEM, WRITE. in_ready = (state==IDLE) or (state==WRITE).
- Acceptance = in_valid & in_ready. On acceptance:
  - reg_write=0: instruction consumed, no write; next state IDLE.
  - reg_write=1, mem_to_reg=0: latch rd_addr, alu_result → WRITE.
  - reg_write=1, mem_to_reg=1: latch rd_addr, load_byte, byte_sel; clear counter → WAIT_MEM.
- WAIT_MEM: mem_rvalid=1 → latch formatted mem_rdata → WRITE. Otherwise counter increments; when the TIMEOUT-th WAIT_MEM cycle ends without mem_rvalid → err=1 next cycle, no write, → IDLE.
- WRITE: rf_we=1 for exactly one cycle with latched address/data; concurrent acceptance is handled as in IDLE (back-to-back ALU instructions write on consecutive cycles).
- Load formatting: word → mem_rdata unchanged; byte → selected 8-bit lane sign-extended to REG_DATA_WIDTH (bit 7 of the lane replicated).
- Writes with rd_addr=0 are suppressed: rf_we stays 0, state sequence unchanged.
- mem_rvalid is ignored outside WAIT_MEM, including in the acceptance cycle.

## Timing
- Reset (rst=0 at clock edge): state IDLE, counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, err=0; in_ready=1 after reset. Reset mid-load abandons the load silently (no err, no write).
- ALU path: accepted in cycle N → rf_we high in cycle N+1.
- Load path: accepted in N, mem_rvalid first seen in M (M≥N+1, M≤N+TIMEOUT) → rf_we high in M+1.
- Timeout: no mem_rvalid in N+1..N+TIMEOUT → err high in N+TIMEOUT+1, in_ready high same cycle.
- rf_waddr/rf_wdata hold their last value when rf_we=0.

## Structure
- Shared package: state encoding constants (IDLE/WAIT_MEM/WRITE), default width and timeout constants.
- One sub-module: load_formatter (combinational: load_byte, byte_sel, mem_rdata → formatted word).

## Test plan
- ALU write: in_valid, reg_write=1, rd_addr=3, alu_result=0x1234 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; one cycle only.
- Byte load: rd_addr=5, load_byte=1, byte_sel=1, mem_rvalid two cycles later with mem_rdata=0x80FF → rf_wdata=0xFF80 one cycle after rvalid; byte_sel=0 with 0x807F → 0x007F.
- Timeout: load accepted, mem_rvalid held 0 → err pulse exactly 9 cycles after acceptance (TIMEOUT=8), no rf_we; rvalid on 8th WAIT_MEM cycle → write, no err.
- Back-to-back: ALU instructions to r1, r2, r3 on consecutive cycles → three consecutive rf_we cycles, in order, in_ready constantly 1.
- r0 and no-write: rd_addr=0 with reg_write=1, and reg_write=0 to r4 → rf_we never asserts.
- Reset mid-load: rst=0 during WAIT_MEM → all outputs 0, no err, later rvalid ignored.
